ysyx_25040105_reg_access_unit: RTL and testbench
================================================

Name: ysyx_25040105_reg_access_unit

Overview:
- Client-side controller for the 2-read/1-write GPR file: the initiator that drives the file's read addresses, write address, write data and write enable.
- Accepts decoded instructions from IDU over valid/ready, reads rs1/rs2 combinationally from the file, and presents registered operands to EXU over valid/ready.
- Tracks in-flight destinations with a 32-bit scoreboard, bypasses same-cycle writeback data and stalls RAW/WAW hazards.
- Owns the single file write port on behalf of WBU.

Parameters:
- ADDR_WIDTH, 5, GPR index width; file depth is 2**ADDR_WIDTH.
- DATA_WIDTH, 32, GPR data width.
- CNT_WIDTH, 16, width of the saturating stall counter.

Ports:
- clk  in  1  clock; all state updates on posedge.
- rst  in  1  asynchronous reset, active-high.
- in_valid  in  1  IDU request valid.
- in_ready  out  1  unit can accept a request this cycle.
- in_rs1  in  ADDR_WIDTH  source 1 index.
- in_rs2  in  ADDR_WIDTH  source 2 index.
- in_rd  in  ADDR_WIDTH  destination index.
- in_rd_wen  in  1  instruction writes rd.
- out_valid  out  1  operands valid to EXU.
- out_ready  in  1  EXU accepts operands.
- out_src1  out  DATA_WIDTH  operand 1.
- out_src2  out  DATA_WIDTH  operand 2.
- out_rd  out  ADDR_WIDTH  destination index.
- out_rd_wen  out  1  destination write flag.
- flush  in  1  discard the output-stage entry.
- wb_valid  in  1  WBU writeback valid; always accepted.
- wb_rd  in  ADDR_WIDTH  writeback index.
- wb_data  in  DATA_WIDTH  writeback data.
- rf_raddr1  out  ADDR_WIDTH  file read address 1; equals in_rs1.
- rf_raddr2  out  ADDR_WIDTH  file read address 2; equals in_rs2.
- rf_rdata1  in  DATA_WIDTH  file read data 1; combinational, index 0 reads 0.
- rf_rdata2  in  DATA_WIDTH  file read data 2.
- rf_waddr  out  ADDR_WIDTH  equals wb_rd.
- rf_wdata  out  DATA_WIDTH  equals wb_data.
- rf_wen  out  1  wb_valid && wb_rd!=0.
- busy_mask  out  2**ADDR_WIDTH  scoreboard state; bit 0 always 0.
- stall_cnt  out  CNT_WIDTH  saturating count of stall cycles.
- wb_err  out  1  sticky: writeback to a register that was not busy.

Behaviour:
- Reset (async, rst=1): busy=0, out_valid=0, out_src1/out_src2/out_rd/out_rd_wen=0, stall_cnt=0, wb_err=0.
- Writeback, every cycle: clr = wb_valid && wb_rd!=0.
  - If clr, busy[wb_rd] is cleared at the next edge.
  - If clr && !busy[wb_rd], wb_err is set at that edge and stays set until reset.
  - wb_rd=0 never clears, never sets wb_err, and never asserts rf_wen.
- Effective busy for hazard checks: eff = busy & ~(clr ? onehot(wb_rd) : 0).
- Hazard, a combinational stall term:
  - (rs1!=0 && eff[rs1]) || (rs2!=0 && eff[rs2]) || (in_rd_wen && rd!=0 && eff[rd]).
- Output stage: stage_free = !out_valid || out_ready.
- in_ready = stage_free && !hazard && !flush. in_ready does not depend on in_valid.
- Accept = in_valid && in_ready. On accept, at the next edge:
  - out_valid=1.
  - out_src1 = (clr && wb_rd==rs1 && rs1!=0) ? wb_data : rf_rdata1; same rule for src2.
  - rs==0 always yields 0.
  - out_rd / out_rd_wen are captured from the request.
  - If in_rd_wen && rd!=0, busy[rd] is set. When set and clear target the same register, set wins.
- Latency: accept -> out_valid exactly 1 cycle. Back-to-back accepts allowed when out_ready=1.
- If out_valid && out_ready && no accept, out_valid drops to 0.
- While out_valid && !out_ready, all out_* hold stable.
- flush (priority over accept):
  - out_valid=0 at the next edge.
  - If the dropped entry had out_rd_wen && out_rd!=0, busy[out_rd] is cleared.
  - No accept occurs in a flush cycle.
- stall_cnt increments when in_valid && !in_ready, saturates at 2**CNT_WIDTH-1 and never wraps.
- Reset asserted mid-operation immediately returns all state to reset values. A pending writeback in that cycle is lost from the scoreboard, but rf_wen still follows wb_valid combinationally.

Test Plan:
- Reset, then issue rs1=1,rs2=2,rd=3,wen=1 with file x1=0x11, x2=0x22 -> next cycle out_valid=1, src1=0x11, src2=0x22, busy_mask=0x8.
- With busy[3] set, issue rs1=3 -> in_ready=0 and stall_cnt increments each cycle. Then wb_valid with wb_rd=3, wb_data=0xDEAD in the same cycle -> accept, src1=0xDEAD, busy[3] cleared.
- Issue rd=5 while busy[5] and wb_rd=5 in the same cycle -> accept, busy[5] remains 1 (set wins), rf_wen=1, rf_waddr=5.
- Issue rs1=0, rd=0, wen=1 with wb_rd=0 -> src1=0, busy_mask=0, rf_wen=0, wb_err=0.
- Holding out_ready=0 for 4 cycles -> out_* stable and in_ready=0. Then flush -> out_valid=0 and busy[out_rd] cleared.
- Writeback to x7 while busy_mask=0 -> wb_err=1, sticky until rst.

Source files
------------

// File: rtl/ysyx_25040105_reg_access_unit.sv
// Operand-fetch stage between IDU and EXU: reads the 2R/1W GPR file, bypasses
// same-cycle writeback, tracks in-flight destinations and owns the file write port.
module ysyx_25040105_reg_access_unit #(
  parameter int ADDR_WIDTH = 5,
  parameter int DATA_WIDTH = 32,
  parameter int CNT_WIDTH  = 16
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [ADDR_WIDTH-1:0]      in_rs1,
  input  logic [ADDR_WIDTH-1:0]      in_rs2,
  input  logic [ADDR_WIDTH-1:0]      in_rd,
  input  logic                       in_rd_wen,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [DATA_WIDTH-1:0]      out_src1,
  output logic [DATA_WIDTH-1:0]      out_src2,
  output logic [ADDR_WIDTH-1:0]      out_rd,
  output logic                       out_rd_wen,
  input  logic                       flush,
  input  logic                       wb_valid,
  input  logic [ADDR_WIDTH-1:0]      wb_rd,
  input  logic [DATA_WIDTH-1:0]      wb_data,
  output logic [ADDR_WIDTH-1:0]      rf_raddr1,
  output logic [ADDR_WIDTH-1:0]      rf_raddr2,
  input  logic [DATA_WIDTH-1:0]      rf_rdata1,
  input  logic [DATA_WIDTH-1:0]      rf_rdata2,
  output logic [ADDR_WIDTH-1:0]      rf_waddr,
  output logic [DATA_WIDTH-1:0]      rf_wdata,
  output logic                       rf_wen,
  output logic [(1<<ADDR_WIDTH)-1:0] busy_mask,
  output logic [CNT_WIDTH-1:0]       stall_cnt,
  output logic                       wb_err
);

  localparam int DEPTH = 1 << ADDR_WIDTH;

  logic [DEPTH-1:0]      r_busy;
  logic                  r_out_valid;
  logic [DATA_WIDTH-1:0] r_out_src1;
  logic [DATA_WIDTH-1:0] r_out_src2;
  logic [ADDR_WIDTH-1:0] r_out_rd;
  logic                  r_out_rd_wen;
  logic [CNT_WIDTH-1:0]  r_stall_cnt;
  logic                  r_wb_err;

  logic                  w_clr;
  logic [DEPTH-1:0]      w_clr_vec;
  logic [DEPTH-1:0]      w_set_vec;
  logic [DEPTH-1:0]      w_drop_vec;
  logic [DEPTH-1:0]      w_eff;
  logic [DEPTH-1:0]      w_busy_next;
  logic                  w_hazard;
  logic                  w_stage_free;
  logic                  w_in_ready;
  logic                  w_accept;
  logic                  w_drop;
  logic [DATA_WIDTH-1:0] w_src1;
  logic [DATA_WIDTH-1:0] w_src2;

  // Register file write port is a straight pass-through of the writeback bus.
  assign w_clr     = wb_valid && (wb_rd != '0);
  assign rf_waddr  = wb_rd;
  assign rf_wdata  = wb_data;
  assign rf_wen    = w_clr;
  assign rf_raddr1 = in_rs1;
  assign rf_raddr2 = in_rs2;

  assign w_drop = flush && r_out_valid && r_out_rd_wen;

  // Per-register scoreboard update; a new claim beats a same-cycle release.
  generate
    for (genvar gi = 0; gi < DEPTH; gi++) begin : g_busy
      if (gi == 0) begin : g_zero
        assign w_clr_vec[gi]   = 1'b0;
        assign w_set_vec[gi]   = 1'b0;
        assign w_drop_vec[gi]  = 1'b0;
        assign w_busy_next[gi] = 1'b0;
      end else begin : g_reg
        assign w_clr_vec[gi]   = w_clr && (wb_rd == ADDR_WIDTH'(gi));
        assign w_set_vec[gi]   = w_accept && in_rd_wen && (in_rd == ADDR_WIDTH'(gi));
        assign w_drop_vec[gi]  = w_drop && (r_out_rd == ADDR_WIDTH'(gi));
        assign w_busy_next[gi] = w_set_vec[gi] |
                                 (r_busy[gi] & ~w_clr_vec[gi] & ~w_drop_vec[gi]);
      end
    end
  endgenerate

  assign w_eff = r_busy & ~w_clr_vec;

  assign w_hazard = ((in_rs1 != '0) && w_eff[in_rs1]) ||
                    ((in_rs2 != '0) && w_eff[in_rs2]) ||
                    (in_rd_wen && (in_rd != '0) && w_eff[in_rd]);

  assign w_stage_free = !r_out_valid || out_ready;
  assign w_in_ready   = w_stage_free && !w_hazard && !flush;
  assign w_accept     = in_valid && w_in_ready;

  // Writeback data arriving this cycle has not reached the file yet, so forward it.
  always_comb begin
    w_src1 = '0;
    w_src2 = '0;
    if (in_rs1 != '0) begin
      w_src1 = (w_clr && (wb_rd == in_rs1)) ? wb_data : rf_rdata1;
    end
    if (in_rs2 != '0) begin
      w_src2 = (w_clr && (wb_rd == in_rs2)) ? wb_data : rf_rdata2;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_busy <= '0;
    end else begin
      r_busy <= w_busy_next;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_out_valid  <= 1'b0;
      r_out_src1   <= '0;
      r_out_src2   <= '0;
      r_out_rd     <= '0;
      r_out_rd_wen <= 1'b0;
    end else if (flush) begin
      r_out_valid <= 1'b0;
    end else if (w_accept) begin
      r_out_valid  <= 1'b1;
      r_out_src1   <= w_src1;
      r_out_src2   <= w_src2;
      r_out_rd     <= in_rd;
      r_out_rd_wen <= in_rd_wen;
    end else if (out_ready) begin
      r_out_valid <= 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_stall_cnt <= '0;
    end else if (in_valid && !w_in_ready && !(&r_stall_cnt)) begin
      r_stall_cnt <= r_stall_cnt + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wb_err <= 1'b0;
    end else if (w_clr && !r_busy[wb_rd]) begin
      r_wb_err <= 1'b1;
    end
  end

  assign in_ready   = w_in_ready;
  assign out_valid  = r_out_valid;
  assign out_src1   = r_out_src1;
  assign out_src2   = r_out_src2;
  assign out_rd     = r_out_rd;
  assign out_rd_wen = r_out_rd_wen;
  assign busy_mask  = r_busy;
  assign stall_cnt  = r_stall_cnt;
  assign wb_err     = r_wb_err;

endmodule

// File: tb/tb_ysyx_25040105_reg_access_unit.sv
// Bench for the register access unit: directed scenarios plus random traffic
// checked against a scoreboard/operand model derived from the block's rules.
module tb_ysyx_25040105_reg_access_unit;
  localparam int AW    = 5;
  localparam int DW    = 32;
  localparam int CW    = 4;
  localparam int DEPTH = 32;
  localparam int SMAX  = 15;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic          in_valid, in_ready, in_rd_wen;
  logic [AW-1:0] in_rs1, in_rs2, in_rd;
  logic          out_valid, out_ready, out_rd_wen;
  logic [DW-1:0] out_src1, out_src2;
  logic [AW-1:0] out_rd;
  logic          flush, wb_valid;
  logic [AW-1:0] wb_rd;
  logic [DW-1:0] wb_data;
  logic [AW-1:0] rf_raddr1, rf_raddr2, rf_waddr;
  logic [DW-1:0] rf_rdata1, rf_rdata2, rf_wdata;
  logic          rf_wen;
  logic [DEPTH-1:0] busy_mask;
  logic [CW-1:0] stall_cnt;
  logic          wb_err;

  ysyx_25040105_reg_access_unit #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .CNT_WIDTH(CW)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_rs1(in_rs1), .in_rs2(in_rs2),
    .in_rd(in_rd), .in_rd_wen(in_rd_wen),
    .out_valid(out_valid), .out_ready(out_ready), .out_src1(out_src1), .out_src2(out_src2),
    .out_rd(out_rd), .out_rd_wen(out_rd_wen),
    .flush(flush), .wb_valid(wb_valid), .wb_rd(wb_rd), .wb_data(wb_data),
    .rf_raddr1(rf_raddr1), .rf_raddr2(rf_raddr2), .rf_rdata1(rf_rdata1), .rf_rdata2(rf_rdata2),
    .rf_waddr(rf_waddr), .rf_wdata(rf_wdata), .rf_wen(rf_wen),
    .busy_mask(busy_mask), .stall_cnt(stall_cnt), .wb_err(wb_err)
  );

  // Environment register file, written only through the unit's write port.
  logic [DW-1:0] gpr [DEPTH];
  assign rf_rdata1 = (rf_raddr1 == '0) ? '0 : gpr[rf_raddr1];
  assign rf_rdata2 = (rf_raddr2 == '0) ? '0 : gpr[rf_raddr2];
  always @(posedge clk) if (rf_wen) gpr[rf_waddr] <= rf_wdata;

  // Reference model state.
  bit [DEPTH-1:0] m_busy;
  bit             m_ov, m_wen, m_err;
  logic [DW-1:0]  m_s1, m_s2;
  logic [AW-1:0]  m_rd;
  int             m_stall;
  logic [DW-1:0]  m_gpr [DEPTH];

  int n_total = 0;
  int n_bad   = 0;

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [DW-1:0] m_src(input logic [AW-1:0] rs);
    if (rs == '0) return '0;
    if (wb_valid && wb_rd != '0 && wb_rd == rs) return wb_data;
    return m_gpr[rs];
  endfunction

  task automatic model_reset();
    m_busy = '0; m_ov = 0; m_wen = 0; m_err = 0;
    m_s1 = '0; m_s2 = '0; m_rd = '0; m_stall = 0;
  endtask

  task automatic idle_inputs();
    in_valid = 0; in_rs1 = '0; in_rs2 = '0; in_rd = '0; in_rd_wen = 0;
    out_ready = 1; flush = 0; wb_valid = 0; wb_rd = '0; wb_data = '0;
  endtask

  task automatic req(input logic [AW-1:0] rs1, input logic [AW-1:0] rs2,
                     input logic [AW-1:0] rd, input logic wen);
    in_valid = 1; in_rs1 = rs1; in_rs2 = rs2; in_rd = rd; in_rd_wen = wen;
  endtask

  // One clock: check combinational outputs, advance model, check registered outputs.
  task automatic tick();
    bit clr, haz, rdy, acc;
    bit [DEPTH-1:0] eff, nb;
    logic [DW-1:0] s1, s2;
    #1;
    clr = wb_valid && wb_rd != '0;
    eff = m_busy;
    if (clr) eff[wb_rd] = 1'b0;
    haz = (in_rs1 != '0 && eff[in_rs1]) || (in_rs2 != '0 && eff[in_rs2]) ||
          (in_rd_wen && in_rd != '0 && eff[in_rd]);
    rdy = (!m_ov || out_ready) && !haz && !flush;
    acc = in_valid && rdy;
    check_val("in_ready", in_ready, rdy);
    check_val("rf_wen", rf_wen, clr);
    check_val("rf_waddr", rf_waddr, wb_rd);
    check_val("rf_wdata", rf_wdata, wb_data);
    check_val("rf_raddr1", rf_raddr1, in_rs1);
    check_val("rf_raddr2", rf_raddr2, in_rs2);
    s1 = m_src(in_rs1);
    s2 = m_src(in_rs2);
    nb = eff;
    if (flush && m_ov && m_wen && m_rd != '0) nb[m_rd] = 1'b0;
    if (acc && in_rd_wen && in_rd != '0) nb[in_rd] = 1'b1;
    if (clr && !m_busy[wb_rd]) m_err = 1;
    if (in_valid && !rdy && m_stall < SMAX) m_stall++;
    if (flush) m_ov = 0;
    else if (acc) begin
      m_ov = 1; m_s1 = s1; m_s2 = s2; m_rd = in_rd; m_wen = in_rd_wen;
    end else if (out_ready) m_ov = 0;
    if (acc)
      $display("xact t=%0t rs1=%0d rs2=%0d rd=%0d wen=%0b src1=%h src2=%h",
               $time, in_rs1, in_rs2, in_rd, in_rd_wen, s1, s2);
    if (clr) m_gpr[wb_rd] = wb_data;
    m_busy = nb;
    @(posedge clk);
    #1;
    check_val("out_valid", out_valid, m_ov);
    if (m_ov) begin
      check_val("out_src1", out_src1, m_s1);
      check_val("out_src2", out_src2, m_s2);
      check_val("out_rd", out_rd, m_rd);
      check_val("out_rd_wen", out_rd_wen, m_wen);
    end
    check_val("busy_mask", busy_mask, m_busy);
    check_val("stall_cnt", stall_cnt, m_stall);
    check_val("wb_err", wb_err, m_err);
    @(negedge clk);
  endtask

  task automatic do_reset();
    idle_inputs();
    rst = 1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check_val("rst_out_valid", out_valid, 0);
    check_val("rst_src1", out_src1, 0);
    check_val("rst_src2", out_src2, 0);
    check_val("rst_rd", out_rd, 0);
    check_val("rst_rd_wen", out_rd_wen, 0);
    check_val("rst_busy", busy_mask, 0);
    check_val("rst_stall", stall_cnt, 0);
    check_val("rst_wb_err", wb_err, 0);
    rst = 0;
    model_reset();
  endtask

  logic [DW-1:0] held_s1, held_s2;

  initial begin
    #1_000_000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

  initial begin
    for (int i = 0; i < DEPTH; i++) m_gpr[i] = '0;
    do_reset();

    // Preload the file through the write port, then clear the resulting error flag.
    for (int i = 1; i < DEPTH; i++) begin
      wb_valid = 1; wb_rd = AW'(i);
      wb_data = (i == 1) ? 32'h11 : (i == 2) ? 32'h22 : $urandom;
      tick();
    end
    do_reset();

    // Basic issue.
    req(5'd1, 5'd2, 5'd3, 1'b1);
    tick();
    check_val("t1_valid", out_valid, 1);
    check_val("t1_src1", out_src1, 32'h11);
    check_val("t1_src2", out_src2, 32'h22);
    check_val("t1_busy", busy_mask, 32'h8);

    // RAW stall then bypass release.
    req(5'd3, 5'd0, 5'd4, 1'b0);
    repeat (3) tick();
    check_val("t2_stall", stall_cnt, 3);
    wb_valid = 1; wb_rd = 5'd3; wb_data = 32'hDEAD;
    tick();
    check_val("t2_src1", out_src1, 32'hDEAD);
    check_val("t2_busy", busy_mask, 0);
    wb_valid = 0;

    // Set wins over same-cycle clear.
    req(5'd0, 5'd0, 5'd5, 1'b1);
    tick();
    wb_valid = 1; wb_rd = 5'd5; wb_data = 32'h55;
    #1;
    check_val("t3_rf_wen", rf_wen, 1);
    check_val("t3_rf_waddr", rf_waddr, 5);
    tick();
    check_val("t3_busy", busy_mask, 32'h20);
    check_val("t3_err", wb_err, 0);
    in_valid = 0;
    tick();

    // x0 handling.
    req(5'd0, 5'd0, 5'd0, 1'b1);
    wb_valid = 1; wb_rd = 5'd0; wb_data = 32'h1234;
    #1;
    check_val("t4_rf_wen", rf_wen, 0);
    tick();
    check_val("t4_src1", out_src1, 0);
    check_val("t4_busy", busy_mask, 0);
    check_val("t4_err", wb_err, 0);
    wb_valid = 0;

    // Backpressure hold, then flush.
    req(5'd1, 5'd2, 5'd6, 1'b1);
    tick();
    held_s1 = out_src1; held_s2 = out_src2;
    out_ready = 0;
    req(5'd1, 5'd2, 5'd9, 1'b1);
    for (int k = 0; k < 4; k++) begin
      tick();
      check_val("t5_hold_src1", out_src1, held_s1);
      check_val("t5_hold_src2", out_src2, held_s2);
      check_val("t5_hold_rd", out_rd, 6);
      check_val("t5_in_ready", in_ready, 0);
    end
    flush = 1;
    tick();
    check_val("t5_flush_valid", out_valid, 0);
    check_val("t5_flush_busy", busy_mask, 0);
    idle_inputs();

    // Spurious writeback, sticky error.
    wb_valid = 1; wb_rd = 5'd7; wb_data = 32'h77;
    tick();
    check_val("t6_err", wb_err, 1);
    wb_valid = 0;
    repeat (3) tick();
    check_val("t6_sticky", wb_err, 1);
    do_reset();

    // Stall counter saturation.
    req(5'd0, 5'd0, 5'd3, 1'b1);
    tick();
    req(5'd3, 5'd0, 5'd0, 1'b0);
    repeat (20) tick();
    check_val("t7_sat", stall_cnt, SMAX);

    // Asynchronous reset mid-operation with a pending writeback.
    req(5'd0, 5'd0, 5'd8, 1'b1);
    wb_valid = 1; wb_rd = 5'd3; wb_data = 32'h33;
    tick();
    in_valid = 0;
    wb_valid = 1; wb_rd = 5'd8; wb_data = 32'h88;
    rst = 1;
    #1;
    check_val("t8_valid", out_valid, 0);
    check_val("t8_busy", busy_mask, 0);
    check_val("t8_stall", stall_cnt, 0);
    check_val("t8_rf_wen", rf_wen, 1);
    m_gpr[8] = 32'h88;
    @(posedge clk);
    @(negedge clk);
    rst = 0;
    model_reset();
    idle_inputs();

    // Random traffic.
    for (int n = 0; n < 1500; n++) begin
      in_valid  = ($urandom_range(0, 9) < 7);
      in_rs1    = AW'($urandom_range(0, 7));
      in_rs2    = AW'($urandom_range(0, 7));
      in_rd     = AW'($urandom_range(0, 7));
      in_rd_wen = ($urandom_range(0, 3) != 0);
      out_ready = ($urandom_range(0, 9) < 7);
      flush     = ($urandom_range(0, 19) == 0);
      wb_valid  = ($urandom_range(0, 9) < 4);
      wb_data   = $urandom;
      if (m_busy != '0 && $urandom_range(0, 3) != 0) begin
        int idx;
        do idx = int'($urandom_range(1, DEPTH - 1)); while (!m_busy[idx]);
        wb_rd = AW'(idx);
      end else begin
        wb_rd = AW'($urandom_range(0, 7));
      end
      tick();
    end

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end
endmodule
